// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes and the
// write/read channel state encodings.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4lite_reg_bank.sv
// AXI4-Lite slave exposing NREG DW-bit registers with byte strobes.
// Define AXI4LITE_REG_BANK_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axi4lite_reg_bank
    import axi4lite_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = 32,
    parameter int NREG = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        awaddr,
    input  logic [2:0]           awprot,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [DW-1:0]        wdata,
    input  logic [DW/8-1:0]      wstrb,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic [AW-1:0]        araddr,
    input  logic [2:0]           arprot,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [DW-1:0]        rdata,
    output logic [1:0]           rresp,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [NREG*DW-1:0]   regs_o,
    output logic [NREG-1:0]      wr_stb_o
);

    localparam int SW   = DW / 8;
    localparam int OFFB = $clog2(SW);
    localparam int IDXW = AW - OFFB;
    localparam int RIW  = (NREG > 1) ? $clog2(NREG) : 1;

`ifdef AXI4LITE_REG_BANK_SLVERR_EN
    localparam resp_t OOR_RESP = SLVERR;
`else
    localparam resp_t OOR_RESP = OKAY;
`endif

    function automatic logic idx_in_range(input logic [IDXW-1:0] idx);
        return 32'(idx) < 32'(NREG);
    endfunction

    wr_state_t        w_state_q, w_state_d;
    logic             aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic             awready_q, awready_d, wready_q, wready_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    logic             bvalid_q, bvalid_d;
    resp_t            bresp_q, bresp_d;
    logic [DW-1:0]    regs_q [NREG];
    logic [DW-1:0]    regs_d [NREG];
    logic [NREG-1:0]  wr_stb_q, wr_stb_d;

    rd_state_t        r_state_q, r_state_d;
    logic             arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    resp_t            rresp_q, rresp_d;

    logic [IDXW-1:0]  w_idx_s, r_idx_s;
    logic [RIW-1:0]   w_ridx_s, r_ridx_s;
    logic             w_in_range_s, r_in_range_s;
    logic             unused_ok_s;

    assign w_idx_s      = waddr_q[AW-1:OFFB];
    assign w_ridx_s     = w_idx_s[RIW-1:0];
    assign w_in_range_s = idx_in_range(w_idx_s);
    assign r_idx_s      = araddr[AW-1:OFFB];
    assign r_ridx_s     = r_idx_s[RIW-1:0];
    assign r_in_range_s = idx_in_range(r_idx_s);
    assign unused_ok_s  = ^{awprot, arprot, awaddr[OFFB-1:0], araddr[OFFB-1:0]};

    // Write channel: capture AW and W independently, commit once both are held.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        wr_stb_d  = '0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    aw_got_d = 1'b1;
                    waddr_d  = awaddr;
                end else begin
                    aw_got_d = aw_got_q;
                end
                if (wvalid && wready_q) begin
                    w_got_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end else begin
                    w_got_d = w_got_q;
                end
                if (aw_got_q && w_got_q) begin
                    if (w_in_range_s) begin
                        for (int b = 0; b < SW; b++) begin
                            if (wstrb_q[b]) begin
                                regs_d[w_ridx_s][b*8 +: 8] = wdata_q[b*8 +: 8];
                            end else begin
                                regs_d[w_ridx_s][b*8 +: 8] = regs_q[w_ridx_s][b*8 +: 8];
                            end
                        end
                        wr_stb_d[w_ridx_s] = 1'b1;
                        bresp_d = OKAY;
                    end else begin
                        bresp_d = OOR_RESP;
                    end
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                aw_got_d  = 1'b0;
                w_got_d   = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_got_d;
        wready_d  = (w_state_d == W_IDLE) && !w_got_d;
    end

    // Read channel: sample the register file at the AR handshake, hold until rready.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rdata_d   = r_in_range_s ? regs_q[r_ridx_s] : '0;
                    rresp_d   = r_in_range_s ? OKAY : OOR_RESP;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rvalid_d  = 1'b0;
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // State and output registers; readies come up on the first edge out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            wr_stb_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wr_stb_q  <= wr_stb_d;
            regs_q    <= regs_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_flat
        assign regs_o[gi*DW +: DW] = regs_q[gi];
    end

    assign awready  = awready_q;
    assign wready   = wready_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign arready  = arready_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign wr_stb_o = wr_stb_q;

endmodule

// File: doc/axi4lite_reg_bank.md
AXI4LITE_REG_BANK -- requirements
Module: axi4lite_reg_bank

Interface
REQ-001 SHALL have parameter AW, default 8, AXI address width in bits.
REQ-002 SHALL have parameter DW, default 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter NREG, default 16, register count; legal range 1..2**(AW-log2(DW/8)).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 awaddr  in  AW  write address.
REQ-007 awprot  in  3  accepted and ignored.
REQ-008 awvalid/awready  in/out  1/1  AW handshake.
REQ-009 wdata  in  DW  write data.
REQ-010 wstrb  in  DW/8  byte-lane enables.
REQ-011 wvalid/wready  in/out  1/1  W handshake.
REQ-012 bresp  out  2  write response.
REQ-013 bvalid/bready  out/in  1/1  B handshake.
REQ-014 araddr  in  AW  read address.
REQ-015 arprot  in  3  accepted and ignored.
REQ-016 arvalid/arready  in/out  1/1  AR handshake.
REQ-017 rdata  out  DW  read data.
REQ-018 rresp  out  2  read response.
REQ-019 rvalid/rready  out/in  1/1  R handshake.
REQ-020 regs_o  out  NREG*DW  all registers, flattened; register i at bits [i*DW +: DW].
REQ-021 wr_stb_o  out  NREG  one-cycle pulse on bit i in the cycle after register i is written.

Function
REQ-022 Decode SHALL use index = addr[AW-1:log2(DW/8)]; low byte-offset bits are ignored; index >= NREG is out-of-range (OOR).
REQ-023 Write FSM states SHALL be W_IDLE and W_RESP.
- W_IDLE: awready and wready start at 1.
- AW and W are captured independently, in either order or in the same cycle.
- Each ready drops after its own handshake.
REQ-024 The edge after both AW and W are captured SHALL:
- update bytes whose wstrb bit is 1 (in-range only);
- set bvalid=1 and enter W_RESP.
REQ-025 In W_RESP, bvalid and bresp SHALL hold stable until bready; awready=wready=0 throughout.
REQ-026 After the B handshake, the FSM SHALL return to W_IDLE on the next edge.
REQ-027 wstrb=0 SHALL leave the register unchanged but still pulse wr_stb_o and respond.
REQ-028 Read FSM states SHALL be R_IDLE (arready=1) and R_DATA (arready=0).
REQ-029 On an AR handshake, the read FSM SHALL register rdata/rresp and raise rvalid on the next edge; hold stable until rready, then return to R_IDLE.
REQ-030 Read and write channels SHALL be fully independent.
REQ-031 A read sampling the same register in the write-commit cycle SHALL return the pre-write value.
REQ-032 OOR writes SHALL modify no register and pulse no wr_stb_o bit; OOR reads SHALL return rdata=0.
REQ-033 Responses: in-range accesses SHALL return OKAY (2'b00); OOR accesses per REQ-038.

Reset
REQ-034 Reset SHALL clear all registers to 0, wr_stb_o=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0.
REQ-035 Reset SHALL set awready=wready=arready=1 on the first edge after reset deasserts.
REQ-036 Reset mid-transaction SHALL abandon all captured AW/W/AR state with no register update; a write committing in the reset cycle is lost.

Configuration
REQ-037 Macro AXI4LITE_REG_BANK_SLVERR_EN SHALL select OOR response behaviour.
REQ-038 Defined: OOR bresp/rresp = SLVERR (2'b10). Undefined: OOR returns OKAY, with REQ-032 data/write behaviour unchanged.

Structure
REQ-039 Package axi4lite_pkg SHALL hold:
- resp enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
- write FSM enum and read FSM enum.
REQ-040 The block SHALL be a single module; no sub-module.

Verification (AW=8, DW=32, NREG=16)
REQ-041 AW at addr 0x08 one cycle before W (0xDEADBEEF, wstrb 4'hF) -> reg2=0xDEADBEEF, wr_stb_o=16'h0004 for one cycle, bresp=00.
REQ-042 reg2=0xDEADBEEF; write 0x11223344 with wstrb 4'b0101 -> reg2=0xDE22BE44.
REQ-043 AW 0x40, W 0x1 with SLVERR_EN -> bresp=10, no regs change; read 0x40 -> rdata=0, rresp=10; repeat without the macro -> responses 00.
REQ-044 bready held low 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout; next write is accepted after the handshake.
REQ-045 Read of 0x08 handshaking in reg2's write-commit cycle (old 0x0, new 0x5) -> rdata=0x0; a following read -> 0x5.
REQ-046 reset asserted while AW is captured but W is pending -> no register change, no bvalid; ready signals as in REQ-035.
